// File: rtl/spi_frame_serializer_if.sv
// ---------------------------------------------------------------------------
// spi_frame_serializer_if
//   Frame handoff between the byte-to-frame output FIFO and the SPI frame
//   serializer, using a valid/ready handshake.
//
//   Signals:
//     frame_in     FRAME_BITS  frame word; bit FRAME_BITS-1 is sent first
//     frame_valid  1           frame_in holds a frame
//     frame_ready  1           serializer is idle and accepts a frame
//
//   Modports:
//     master  FIFO side (drives frame_in / frame_valid)
//     slave   serializer side (drives frame_ready)
// ---------------------------------------------------------------------------
interface spi_frame_serializer_if #(
  parameter int FRAME_BITS = 120
);
  logic [FRAME_BITS-1:0] frame_in;
  logic                  frame_valid;
  logic                  frame_ready;

  modport master (output frame_in, output frame_valid, input frame_ready);
  modport slave  (input  frame_in, input  frame_valid, output frame_ready);
endinterface

// File: rtl/spi_frame_serializer.sv
// ---------------------------------------------------------------------------
// spi_frame_serializer
//   Shifts one FRAME_BITS-wide frame out on MISO, MSB first, SPI mode 0
//   (SCLK idles low, receiver samples on SCLK rising). Each bit spends
//   CLK_DIV system clocks with SCLK low and then CLK_DIV clocks with SCLK
//   high. After the last bit, CS_N stays low for a CLK_DIV-cycle hold,
//   then CS_N rises together with a one-cycle DONE pulse.
//
//   Optional feature macro: SPI_FRAME_PARITY_EN
//     defined   -> one extra even-parity bit (XOR of the captured frame) is
//                  sent after the last data bit, N = FRAME_BITS + 1
//     undefined -> N = FRAME_BITS, no parity logic
//
//   Parameters:
//     FRAME_BITS  frame width, multiple of 8, >= 8
//     CLK_DIV     system clocks per SCLK half-period, >= 1
//
//   Ports:
//     clk       in   system clock, rising edge
//     rst       in   asynchronous active-low reset
//     frame_if  slave  frame_in / frame_valid in, frame_ready out
//     sclk      out  SPI clock, idles low
//     miso      out  serial data
//     cs_n      out  chip select, active low
//     busy      out  a frame is in flight
//     done      out  one-cycle pulse at the end of a frame
// ---------------------------------------------------------------------------
module spi_frame_serializer #(
  parameter int FRAME_BITS = 120,
  parameter int CLK_DIV    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  spi_frame_serializer_if.slave   frame_if,
  output logic                    sclk,
  output logic                    miso,
  output logic                    cs_n,
  output logic                    busy,
  output logic                    done
);

`ifdef SPI_FRAME_PARITY_EN
  localparam int NBITS = FRAME_BITS + 1;
`else
  localparam int NBITS = FRAME_BITS;
`endif

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = $clog2(NBITS + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(NBITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_HOLD
  } state_t;

  state_t             r_state;
  logic [NBITS-1:0]   r_shift;
  logic [DIV_W-1:0]   r_div;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic               r_sclk;
  logic               r_miso;
  logic               r_cs_n;
  logic               r_busy;
  logic               r_done;
  logic               r_frame_ready;

  logic [NBITS-1:0]   w_load;
  logic               w_div_end;

  // The shift register is loaded with the whole transmission, so the parity
  // bit (when present) simply rides along as the final bit.
`ifdef SPI_FRAME_PARITY_EN
  assign w_load = {frame_if.frame_in, ^frame_if.frame_in};
`else
  assign w_load = frame_if.frame_in;
`endif

  // Last system clock of the current SCLK half-period (or of the hold).
  assign w_div_end = (r_div == DIV_LAST);

  // NOTE: sequential state uses non-blocking (<=) assignments only, so every
  // register in this block sees the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the shift register is reset as well; it is small, and this
      // keeps no stale frame data around after a mid-frame abort.
      r_state       <= S_IDLE;
      r_shift       <= '0;
      r_div         <= '0;
      r_bit_cnt     <= '0;
      r_sclk        <= 1'b0;
      r_miso        <= 1'b0;
      r_cs_n        <= 1'b1;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_frame_ready <= 1'b0;
    end else begin
      r_done <= 1'b0;

      unique case (r_state)
        S_IDLE: begin
          r_cs_n <= 1'b1;
          r_sclk <= 1'b0;
          // Gating on the registered ready keeps the first edge after reset
          // from capturing a frame that was already valid.
          if (frame_if.frame_valid && r_frame_ready) begin
            r_shift       <= w_load;
            r_miso        <= w_load[NBITS-1];
            r_cs_n        <= 1'b0;
            r_busy        <= 1'b1;
            r_frame_ready <= 1'b0;
            r_div         <= '0;
            r_bit_cnt     <= '0;
            r_state       <= S_SHIFT;
          end else begin
            r_frame_ready <= 1'b1;
          end
        end

        S_SHIFT: begin
          if (!w_div_end) begin
            r_div <= r_div + 1'b1;
          end else begin
            r_div <= '0;
            if (!r_sclk) begin
              r_sclk <= 1'b1;
            end else begin
              // End of the high phase: SCLK falls and MISO advances together.
              r_sclk <= 1'b0;
              if (r_bit_cnt == BIT_LAST) begin
                r_bit_cnt <= '0;
                r_state   <= S_HOLD;
              end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
                r_shift   <= r_shift << 1;
                r_miso    <= r_shift[NBITS-2];
              end
            end
          end
        end

        S_HOLD: begin
          // MISO keeps the last bit for the whole hold.
          if (!w_div_end) begin
            r_div <= r_div + 1'b1;
          end else begin
            r_div         <= '0;
            r_cs_n        <= 1'b1;
            r_busy        <= 1'b0;
            r_done        <= 1'b1;
            r_miso        <= 1'b0;
            r_frame_ready <= 1'b1;
            r_state       <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign sclk                 = r_sclk;
  assign miso                 = r_miso;
  assign cs_n                 = r_cs_n;
  assign busy                 = r_busy;
  assign done                 = r_done;
  assign frame_if.frame_ready = r_frame_ready;

endmodule

// File: tb/tb_spi_frame_serializer.sv
// ---------------------------------------------------------------------------
// tb_spi_frame_serializer
//   Self-checking bench for spi_frame_serializer (FRAME_BITS=120, CLK_DIV=4).
//   The expected waveform of every frame is derived from the frame value as a
//   queue of bits in transmission order (MSB first, then parity when
//   SPI_FRAME_PARITY_EN is defined) and from the bit-period arithmetic.
// ---------------------------------------------------------------------------
module tb_spi_frame_serializer;

  localparam int FB = 120;
  localparam int D  = 4;
`ifdef SPI_FRAME_PARITY_EN
  localparam int NB = FB + 1;
`else
  localparam int NB = FB;
`endif
  localparam int CS_LOW = 2 * D * NB + D;
  localparam int BUDGET = CS_LOW + 50;

  logic clk;
  logic rst;
  logic sclk, miso, cs_n, busy, done;

  int compared   = 0;
  int mismatched = 0;

  logic [NB-1:0] rx;

  spi_frame_serializer_if #(.FRAME_BITS(FB)) frame_if ();

  spi_frame_serializer #(
    .FRAME_BITS (FB),
    .CLK_DIV    (D)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .frame_if (frame_if),
    .sclk     (sclk),
    .miso     (miso),
    .cs_n     (cs_n),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [FB-1:0] rand_frame();
    logic [127:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    return r[FB-1:0];
  endfunction

  // Watches one frame starting at the first sample after its capture edge.
  // Returns at the sample where cs_n is high again (the done sample).
  task automatic watch_frame(input logic [FB-1:0] f, input string name,
                             input int inject_at, input bit drop_valid,
                             output logic [NB-1:0] rx_o);
    bit q[$];
    logic [NB-1:0] exp_vec;
    int s, rises, low;
    bit prev_sclk, wave_err, ctrl_err;
    logic exp_miso, exp_sclk;

    for (int k = FB - 1; k >= 0; k--) q.push_back(f[k]);
`ifdef SPI_FRAME_PARITY_EN
    q.push_back(($countones(f) % 2) == 1);
`endif
    for (int k = 0; k < NB; k++) exp_vec[NB-1-k] = q[k];

    rx_o = '0; s = 0; rises = 0; low = 0;
    prev_sclk = 1'b0; wave_err = 1'b0; ctrl_err = 1'b0;

    while (s < BUDGET && cs_n === 1'b0) begin
      low++;
      exp_sclk = (s < 2 * D * NB) && ((s % (2 * D)) >= D);
      exp_miso = (s < 2 * D * NB) ? q[s / (2 * D)] : q[NB-1];
      if (sclk !== exp_sclk || miso !== exp_miso) wave_err = 1'b1;
      if (frame_if.frame_ready !== 1'b0 || busy !== 1'b1 || done !== 1'b0) ctrl_err = 1'b1;
      if (sclk === 1'b1 && !prev_sclk) begin
        if (rises < NB) rx_o[NB-1-rises] = miso;
        rises++;
      end
      prev_sclk = (sclk === 1'b1);
      if (s == 0 && drop_valid) frame_if.frame_valid = 1'b0;
      if (inject_at >= 0 && s == inject_at) begin
        frame_if.frame_valid = 1'b1;
        frame_if.frame_in    = '1;
      end
      if (inject_at >= 0 && s == inject_at + 1) begin
        frame_if.frame_valid = 1'b0;
        frame_if.frame_in    = f;
      end
      @(negedge clk);
      s++;
    end

    compared++;
    if (s >= BUDGET) begin
      mismatched++;
      $display("FAIL %s_timeout: cs_n still low after %0d cycles, required high by %0d", name, s, CS_LOW);
    end
    compared++;
    if (low != CS_LOW) begin
      mismatched++;
      $display("FAIL %s_cs_low: got %0d cycles, expected %0d", name, low, CS_LOW);
    end
    compared++;
    if (rises != NB) begin
      mismatched++;
      $display("FAIL %s_sclk_rises: got %0d, expected %0d", name, rises, NB);
    end
    compared++;
    if (rx_o !== exp_vec) begin
      mismatched++;
      $display("FAIL %s_data: got %h, expected %h", name, rx_o, exp_vec);
    end
    compared++;
    if (wave_err) begin
      mismatched++;
      $display("FAIL %s_waveform: sclk/miso deviated from bit timing, got err=1 expected err=0", name);
    end
    compared++;
    if (ctrl_err) begin
      mismatched++;
      $display("FAIL %s_ctrl: ready/busy/done wrong while cs_n low, got err=1 expected err=0", name);
    end
    compared++;
    if (done !== 1'b1) begin
      mismatched++;
      $display("FAIL %s_done: got %b at cs_n rise, expected 1", name, done);
    end
    compared++;
    if ({busy, frame_if.frame_ready, miso, sclk} !== 4'b0100) begin
      mismatched++;
      $display("FAIL %s_end_state: got busy/ready/miso/sclk=%b, expected 0100", name,
               {busy, frame_if.frame_ready, miso, sclk});
    end
  endtask

  // Presents a frame for one cycle, watches it, then checks the done width.
  task automatic send_frame(input logic [FB-1:0] f, input string name,
                            input int inject_at, output logic [NB-1:0] rx_o);
    int w = 0;
    while (frame_if.frame_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    compared++;
    if (frame_if.frame_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL %s_ready_wait: got ready=%b, expected 1", name, frame_if.frame_ready);
    end
    frame_if.frame_in    = f;
    frame_if.frame_valid = 1'b1;
    @(negedge clk);
    watch_frame(f, name, inject_at, 1'b1, rx_o);
    @(negedge clk);
    compared++;
    if (done !== 1'b0 || cs_n !== 1'b1) begin
      mismatched++;
      $display("FAIL %s_done_width: got done=%b cs_n=%b, expected done=0 cs_n=1", name, done, cs_n);
    end
  endtask

  task automatic test_reset();
    frame_if.frame_valid = 1'b1;
    frame_if.frame_in    = rand_frame();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if ({cs_n, sclk, miso, frame_if.frame_ready, busy, done} !== 6'b100000) begin
      mismatched++;
      $display("FAIL reset_values: got cs_n/sclk/miso/ready/busy/done=%b, expected 100000",
               {cs_n, sclk, miso, frame_if.frame_ready, busy, done});
    end
    rst = 1'b1;
    #1;
    compared++;
    if (frame_if.frame_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_release_ready: got %b before first edge, expected 0", frame_if.frame_ready);
    end
    @(negedge clk);
    compared++;
    if (frame_if.frame_ready !== 1'b1 || cs_n !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_first_edge: got ready=%b cs_n=%b, expected ready=1 cs_n=1",
               frame_if.frame_ready, cs_n);
    end
    frame_if.frame_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_frame();
    logic [FB-1:0] f;
    f = 120'h01_02_14_1E_28_32_3C_46_64_78_82_8C_96_00_00;
    send_frame(f, "single", -1, rx);
  endtask

  task automatic test_busy_rejection();
    logic [FB-1:0] f;
    f = rand_frame();
    send_frame(f, "busy_reject", 300, rx);
    // The rejected all-ones frame must not have been queued.
    repeat (4) @(negedge clk);
    compared++;
    if (cs_n !== 1'b1 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL busy_reject_no_queue: got cs_n=%b busy=%b, expected cs_n=1 busy=0", cs_n, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [FB-1:0] fa, fb;
    fa = {15{8'hAA}};
    fb = {15{8'h55}};
    frame_if.frame_in    = fa;
    frame_if.frame_valid = 1'b1;
    @(negedge clk);
    watch_frame(fa, "b2b_first", -1, 1'b0, rx);
    frame_if.frame_in = fb;
    @(negedge clk);
    compared++;
    if (cs_n !== 1'b0) begin
      mismatched++;
      $display("FAIL b2b_gap: got cs_n=%b one cycle after done, expected 0", cs_n);
    end
    watch_frame(fb, "b2b_second", -1, 1'b1, rx);
    @(negedge clk);
  endtask

  task automatic test_mid_frame_reset();
    int s = 0;
    bit saw_done = 1'b0;
    frame_if.frame_in    = rand_frame();
    frame_if.frame_valid = 1'b1;
    @(negedge clk);
    frame_if.frame_valid = 1'b0;
    while (s < 2 * 60 * D + D + 1) begin
      @(negedge clk);
      s++;
    end
    compared++;
    if (sclk !== 1'b1 || cs_n !== 1'b0) begin
      mismatched++;
      $display("FAIL midreset_pre: got sclk=%b cs_n=%b in bit 60 high phase, expected 1/0", sclk, cs_n);
    end
    #1 rst = 1'b0;
    #1;
    compared++;
    if ({cs_n, sclk, miso, busy, frame_if.frame_ready} !== 5'b10000) begin
      mismatched++;
      $display("FAIL midreset_async: got cs_n/sclk/miso/busy/ready=%b, expected 10000",
               {cs_n, sclk, miso, busy, frame_if.frame_ready});
    end
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0) saw_done = 1'b1;
    end
    rst = 1'b1;
    @(negedge clk);
    if (done !== 1'b0) saw_done = 1'b1;
    compared++;
    if (saw_done) begin
      mismatched++;
      $display("FAIL midreset_no_done: got done pulse after abort, expected none");
    end
    send_frame(rand_frame(), "midreset_fresh", -1, rx);
  endtask

  task automatic test_random_frames();
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      send_frame(rand_frame(), $sformatf("random%0d", i), -1, rx);
    end
  endtask

`ifdef SPI_FRAME_PARITY_EN
  task automatic test_parity();
    logic [FB-1:0] f;
    f = '0;
    f[0] = 1'b1;
    send_frame(f, "parity_one", -1, rx);
    compared++;
    if (rx[0] !== 1'b1) begin
      mismatched++;
      $display("FAIL parity_one_bit: got %b, expected 1", rx[0]);
    end
    send_frame('0, "parity_zero", -1, rx);
    compared++;
    if (rx[0] !== 1'b0) begin
      mismatched++;
      $display("FAIL parity_zero_bit: got %b, expected 0", rx[0]);
    end
  endtask
`endif

  initial begin
    rst                  = 1'b1;
    frame_if.frame_valid = 1'b0;
    frame_if.frame_in    = '0;
    #2;
    test_reset();
    test_single_frame();
    test_busy_rejection();
    test_back_to_back();
    test_mid_frame_reset();
    test_random_frames();
`ifdef SPI_FRAME_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
